fp_align_stage: RTL
===================

// Module: fp_align_stage
// PURPOSE
//  Operand alignment stage of the FP add/sub datapath, directly downstream of exponent compare.
//  Orders operands by magnitude, takes the larger exponent, and right-shifts the smaller
//  significand by the exponent difference, producing guard/round/sticky bits.
//  2-stage pipeline with valid/ready handshake; feeds the significand adder/subtractor.
// PARAMETERS
//  EXP_WIDTH   8    exponent field width (biased)
//  MANT_WIDTH  23   stored fraction width (hidden bit not included)
// PORTS
//  clk          in   1              single clock; all state on rising edge
//  rst          in   1              synchronous, active-high reset
//  in_valid     in   1              input operands valid
//  in_ready     out  1              stage can accept input this cycle
//  op_sub       in   1              0 = A+B, 1 = A-B
//  sign_a/b     in   1              operand signs
//  exp_a/b      in   EXP_WIDTH      biased exponents
//  frac_a/b     in   MANT_WIDTH     fractions
//  out_valid    out  1              aligned result valid
//  out_ready    in   1              downstream accepts result
//  exp_out      out  EXP_WIDTH      larger (effective) exponent
//  sign_big     out  1              sign of larger-magnitude operand (B sign already xor op_sub)
//  eff_sub      out  1              effective subtraction = sign_a ^ sign_b ^ op_sub
//  swapped      out  1              1 when B is the larger-magnitude operand
//  mant_big     out  MANT_WIDTH+4   {hidden, frac, 3'b000}
//  mant_small   out  MANT_WIDTH+4   {hidden, frac, G, R, S} after right shift
// BEHAVIOUR
//  - Hidden bit = (exp != 0); effective exponent = (exp == 0) ? 1 : exp (denormals).
//  - Stage 1 (registered): compare eff exponents; larger exp wins; on equal exponents larger
//    frac wins; full tie -> A is big, swapped=0. diff = exp_big - exp_small (unsigned, no wrap).
//  - Stage 2 (registered): mant_small = {hid,frac,3'b0} >> diff; S bit = S | OR of all bits
//    shifted below position 0. diff >= MANT_WIDTH+4 -> mant_small = {..0, S=|{hid,frac}}.
//    diff = 0 -> mant_small unchanged, GRS = 000.
//  - Latency: 2 cycles accept->out_valid with out_ready held high; throughput 1/cycle.
//  - Handshake: transfer on valid&&ready. s2_adv = !s2_valid || out_ready;
//    s1_adv = !s1_valid || s2_adv; in_ready = s1_adv (combinational from out_ready, no bubble).
//  - Stall: out_valid high and out_ready low -> all outputs held stable, in_ready low once
//    both stages full. out_valid never drops without transfer.
//  - Simultaneous accept+emit in same cycle is legal and loses no data.
//  - Reset: out_valid=0, internal valids=0, all data outputs=0, in_ready=1 the cycle after
//    rst deasserts. Reset mid-operation discards in-flight operands; no partial output.
//  - NaN/Inf (exp all-ones) passed through as ordinary values; special handling downstream.
// STRUCTURE
//  - fp_pkg: EXP_WIDTH/MANT_WIDTH defaults, GRS_W=3, ALIGN_W=MANT_WIDTH+1+GRS_W,
//    typedef struct align_op_t {sign,exp,mant} shared with adder/normalizer stages.
//  - Sub-module fp_rshift_sticky (ALIGN_W, shift amount in; shifted value with sticky out),
//    purely combinational, instantiated in stage 2.
// TESTING
//  1 exp_a=0x81,frac_a=0,exp_b=0x80,frac_b=0,op_sub=0 -> exp_out=0x81,mant_big=0x4000000,
//    mant_small=0x2000000,swapped=0,eff_sub=0, out_valid 2 cycles after accept.
//  2 exp_a=0x7F,exp_b=0x82,frac_a=0x000001 -> swapped=1,exp_out=0x82,diff=3,
//    small=0x0800000 (hid=1 >>3), S=1 from frac LSB shifted past R.
//  3 diff=40 (exp_a=0x9F,exp_b=0x77) -> mant_small=0x0000001 (sticky only).
//  4 exp equal 0x80, frac_a=0x100000, frac_b=0x200000 -> swapped=1, GRS=000, diff=0;
//    sign_a=0,sign_b=0,op_sub=1 -> eff_sub=1, sign_big=1.
//  5 denormal: exp_a=0,frac_a=0x400000, exp_b=0x01 -> both eff exp 1, hidden 0 vs 1,
//    swapped=1, exp_out=0x01.
//  6 back-to-back 4 operands, out_ready low cycles 3-5 -> in_ready low once full, outputs
//    stable, all 4 delivered in order; rst pulse mid-stream -> out_valid=0 next cycle.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FP datapath definitions: field widths, alignment width and the
// operand record passed between the align, add/sub and normalize stages.
package fp_pkg;

  localparam int FP_EXP_WIDTH  = 8;
  localparam int FP_MANT_WIDTH = 23;
  localparam int GRS_W         = 3;
  localparam int FP_ALIGN_W    = FP_MANT_WIDTH + 1 + GRS_W;

  typedef struct packed {
    logic                    sign;
    logic [FP_EXP_WIDTH-1:0] exp;
    logic [FP_ALIGN_W-1:0]   mant;
  } align_op_t;

endpackage

// File: rtl/fp_rshift_sticky.sv
// Combinational right shifter that folds every bit shifted past position 0
// into the sticky (LSB) position of the result.
module fp_rshift_sticky #(
  parameter int W   = 27,
  parameter int SHW = 8
) (
  input  logic [W-1:0]   in_val,
  input  logic [SHW-1:0] shamt,
  output logic [W-1:0]   out_val
);

  logic [W-1:0] shifted_s;
  logic [W-1:0] mask_s;
  logic         lost_s;

  // Shift, then OR the discarded bits back into the sticky position.
  always_comb begin
    shifted_s = {W{1'b0}};
    mask_s    = {W{1'b0}};
    lost_s    = 1'b0;
    if (int'(shamt) >= W) begin
      // Everything falls off: only the sticky summary survives.
      shifted_s = {W{1'b0}};
      lost_s    = |in_val;
    end else begin
      mask_s    = ~({W{1'b1}} << shamt);
      shifted_s = in_val >> shamt;
      lost_s    = |(in_val & mask_s);
    end
    out_val = {shifted_s[W-1:1], shifted_s[0] | lost_s};
  end

endmodule

// File: rtl/fp_align_stage.sv
// FP add/sub operand alignment: stage 1 orders operands and computes the
// exponent difference, stage 2 shifts the smaller significand with GRS.
module fp_align_stage
  import fp_pkg::*;
#(
  parameter int EXP_WIDTH  = FP_EXP_WIDTH,
  parameter int MANT_WIDTH = FP_MANT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    op_sub,
  input  logic                    sign_a,
  input  logic                    sign_b,
  input  logic [EXP_WIDTH-1:0]    exp_a,
  input  logic [EXP_WIDTH-1:0]    exp_b,
  input  logic [MANT_WIDTH-1:0]   frac_a,
  input  logic [MANT_WIDTH-1:0]   frac_b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [EXP_WIDTH-1:0]    exp_out,
  output logic                    sign_big,
  output logic                    eff_sub,
  output logic                    swapped,
  output logic [MANT_WIDTH+3:0]   mant_big,
  output logic [MANT_WIDTH+3:0]   mant_small
);

  localparam int ALIGN_W = MANT_WIDTH + 1 + GRS_W;
  localparam logic [EXP_WIDTH-1:0] EXP_ZERO = {EXP_WIDTH{1'b0}};
  localparam logic [EXP_WIDTH-1:0] EXP_ONE  = {{(EXP_WIDTH-1){1'b0}}, 1'b1};

  // Stage-1 combinational compare results
  logic                  hid_a_s;
  logic                  hid_b_s;
  logic [EXP_WIDTH-1:0]  eff_exp_a_s;
  logic [EXP_WIDTH-1:0]  eff_exp_b_s;
  logic [MANT_WIDTH:0]   sig_a_s;
  logic [MANT_WIDTH:0]   sig_b_s;
  logic                  a_big_s;
  logic                  sign_b_eff_s;
  logic [EXP_WIDTH-1:0]  exp_big_s;
  logic [EXP_WIDTH-1:0]  diff_s;
  logic [ALIGN_W-1:0]    mant_big_s;
  logic [ALIGN_W-1:0]    mant_small_s;
  logic                  sign_big_s;

  // Stage-1 registers
  logic                  s1_valid_r;
  logic                  s1_sign_r;
  logic                  s1_eff_sub_r;
  logic                  s1_swapped_r;
  logic [EXP_WIDTH-1:0]  s1_exp_r;
  logic [EXP_WIDTH-1:0]  s1_diff_r;
  logic [ALIGN_W-1:0]    s1_mant_big_r;
  logic [ALIGN_W-1:0]    s1_mant_small_r;

  // Handshake and stage-2 shifter output
  logic                  s1_adv_s;
  logic                  s2_adv_s;
  logic [ALIGN_W-1:0]    shifted_s;

  assign s2_adv_s = !out_valid || out_ready;
  assign s1_adv_s = !s1_valid_r || s2_adv_s;
  assign in_ready = s1_adv_s;

  // Denormal handling, magnitude ordering and exponent difference.
  always_comb begin
    hid_a_s      = (exp_a != EXP_ZERO);
    hid_b_s      = (exp_b != EXP_ZERO);
    eff_exp_a_s  = hid_a_s ? exp_a : EXP_ONE;
    eff_exp_b_s  = hid_b_s ? exp_b : EXP_ONE;
    sig_a_s      = {hid_a_s, frac_a};
    sig_b_s      = {hid_b_s, frac_b};
    sign_b_eff_s = sign_b ^ op_sub;
    // Including the hidden bit lets a denormal lose to exp=1 at equal eff exp.
    a_big_s      = (eff_exp_a_s > eff_exp_b_s) ||
                   ((eff_exp_a_s == eff_exp_b_s) && (sig_a_s >= sig_b_s));
    if (a_big_s) begin
      exp_big_s    = eff_exp_a_s;
      diff_s       = eff_exp_a_s - eff_exp_b_s;
      mant_big_s   = {sig_a_s, {GRS_W{1'b0}}};
      mant_small_s = {sig_b_s, {GRS_W{1'b0}}};
      sign_big_s   = sign_a;
    end else begin
      exp_big_s    = eff_exp_b_s;
      diff_s       = eff_exp_b_s - eff_exp_a_s;
      mant_big_s   = {sig_b_s, {GRS_W{1'b0}}};
      mant_small_s = {sig_a_s, {GRS_W{1'b0}}};
      sign_big_s   = sign_b_eff_s;
    end
  end

  // Stage-1 register: loads on accepted input, holds while stage 2 is stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_r      <= 1'b0;
      s1_sign_r       <= 1'b0;
      s1_eff_sub_r    <= 1'b0;
      s1_swapped_r    <= 1'b0;
      s1_exp_r        <= EXP_ZERO;
      s1_diff_r       <= EXP_ZERO;
      s1_mant_big_r   <= {ALIGN_W{1'b0}};
      s1_mant_small_r <= {ALIGN_W{1'b0}};
    end else if (s1_adv_s) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_sign_r       <= sign_big_s;
        s1_eff_sub_r    <= sign_a ^ sign_b ^ op_sub;
        s1_swapped_r    <= !a_big_s;
        s1_exp_r        <= exp_big_s;
        s1_diff_r       <= diff_s;
        s1_mant_big_r   <= mant_big_s;
        s1_mant_small_r <= mant_small_s;
      end else begin
        s1_sign_r       <= s1_sign_r;
        s1_eff_sub_r    <= s1_eff_sub_r;
        s1_swapped_r    <= s1_swapped_r;
        s1_exp_r        <= s1_exp_r;
        s1_diff_r       <= s1_diff_r;
        s1_mant_big_r   <= s1_mant_big_r;
        s1_mant_small_r <= s1_mant_small_r;
      end
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  fp_rshift_sticky #(
    .W   (ALIGN_W),
    .SHW (EXP_WIDTH)
  ) u_rshift (
    .in_val  (s1_mant_small_r),
    .shamt   (s1_diff_r),
    .out_val (shifted_s)
  );

  // Stage-2 output register: outputs stay frozen while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      exp_out    <= EXP_ZERO;
      sign_big   <= 1'b0;
      eff_sub    <= 1'b0;
      swapped    <= 1'b0;
      mant_big   <= {ALIGN_W{1'b0}};
      mant_small <= {ALIGN_W{1'b0}};
    end else if (s2_adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        exp_out    <= s1_exp_r;
        sign_big   <= s1_sign_r;
        eff_sub    <= s1_eff_sub_r;
        swapped    <= s1_swapped_r;
        mant_big   <= s1_mant_big_r;
        mant_small <= shifted_s;
      end else begin
        exp_out    <= exp_out;
        sign_big   <= sign_big;
        eff_sub    <= eff_sub;
        swapped    <= swapped;
        mant_big   <= mant_big;
        mant_small <= mant_small;
      end
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule
